// File: rtl/ariane_pc_trace_pkg.sv
// Shared types and constants for the Ariane commit-stream PC trace.
package ariane_pc_trace_pkg;

  localparam int unsigned DEFAULT_PC_W  = 64;
  localparam int unsigned DEFAULT_DEPTH = 4;

  typedef logic [DEFAULT_PC_W-1:0] pc_t;

  // Base of the print-via-PC window; the console decoder reads a byte from bits 8:1.
  localparam pc_t PRINT_PC_BASE = 64'h0000_0000_8000_0400;

  function automatic logic [1:0] popcount2(input logic [1:0] v);
    return {1'b0, v[0]} + {1'b0, v[1]};
  endfunction

endpackage

// File: rtl/pc_trace_fifo.sv
// Two-write / one-read FIFO; occupancy is tracked as a level, not derived from pointers.
module pc_trace_fifo
  import ariane_pc_trace_pkg::*;
#(
  parameter int unsigned DEPTH = DEFAULT_DEPTH,
  parameter int unsigned PC_W  = DEFAULT_PC_W,
  localparam int unsigned PTR_W = $clog2(DEPTH),
  localparam int unsigned LVL_W = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst_l,
  input  logic [1:0]       wr_cnt,
  input  logic [PC_W-1:0]  wr_data0,
  input  logic [PC_W-1:0]  wr_data1,
  input  logic             pop,
  output logic [PC_W-1:0]  rd_data,
  output logic [LVL_W-1:0] level
);

  logic [PC_W-1:0]  mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] wr_ptr_p1;
  logic [PTR_W-1:0] rd_ptr;

  assign wr_ptr_p1 = wr_ptr + PTR_W'(1);
  assign rd_data   = mem[rd_ptr];

  // Storage needs no reset; only entries counted by level are ever read.
  always_ff @(posedge clk) begin
    if (wr_cnt != 2'd0) mem[wr_ptr] <= wr_data0;
    if (wr_cnt == 2'd2) mem[wr_ptr_p1] <= wr_data1;
  end

  always_ff @(posedge clk or posedge rst_l) begin
    if (rst_l) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      wr_ptr <= wr_ptr + PTR_W'(wr_cnt);
      if (pop) rd_ptr <= rd_ptr + PTR_W'(1);
      level  <= level + LVL_W'(wr_cnt) - LVL_W'(pop);
    end
  end

endmodule

// File: rtl/ariane_pc_trace.sv
// Serializes the dual-port commit stream into a single-beat retirement PC trace,
// buffering two-commit cycles and counting (never hiding) dropped PCs.
module ariane_pc_trace
  import ariane_pc_trace_pkg::*;
#(
  parameter int unsigned DEPTH  = DEFAULT_DEPTH,
  parameter int unsigned PC_W   = DEFAULT_PC_W,
  parameter int unsigned CNT_W  = 32,
  parameter int unsigned DROP_W = 16,
  localparam int unsigned LVL_W = $clog2(DEPTH) + 1
) (
  input  logic              clk,
  input  logic              rst_l,
  input  logic              trace_en,
  input  logic [1:0]        commit_vld,
  input  logic [PC_W-1:0]   commit_pc0,
  input  logic [PC_W-1:0]   commit_pc1,
  output logic              piton_pc_vld,
  output logic [PC_W-1:0]   piton_pc,
  output logic              overflow,
  output logic [DROP_W-1:0] drop_cnt,
  output logic [CNT_W-1:0]  retire_cnt,
  output logic [LVL_W-1:0]  fifo_level
);

  localparam logic [LVL_W:0] DEPTH_X = (LVL_W+1)'(DEPTH);

  logic [1:0]        push_set;
  logic [1:0]        n_req;
  logic [1:0]        n_push;
  logic [1:0]        n_drop;
  logic [LVL_W:0]    free_x;
  logic [LVL_W-1:0]  level;
  logic              pop;
  logic [PC_W-1:0]   head;
  logic [PC_W-1:0]   slot0;
  logic [DROP_W:0]   drop_sum;
  logic [CNT_W-1:0]  retire_nxt;

  // Older entries win the free slots; the youngest commit is the one dropped.
  always_comb begin
    push_set = commit_vld & {2{trace_en}};
    n_req    = popcount2(push_set);
    slot0    = push_set[0] ? commit_pc0 : commit_pc1;
    pop      = (level != '0);
    free_x   = DEPTH_X - {1'b0, level} + {{LVL_W{1'b0}}, pop};
    n_push   = n_req;
    if ({{(LVL_W-1){1'b0}}, n_req} > free_x) n_push = free_x[1:0];
    n_drop   = n_req - n_push;
    drop_sum = {1'b0, drop_cnt} + {{(DROP_W-1){1'b0}}, n_drop};
    retire_nxt = retire_cnt + {{(CNT_W-2){1'b0}}, popcount2(commit_vld)};
  end

  pc_trace_fifo #(
    .DEPTH (DEPTH),
    .PC_W  (PC_W)
  ) u_fifo (
    .clk      (clk),
    .rst_l    (rst_l),
    .wr_cnt   (n_push),
    .wr_data0 (slot0),
    .wr_data1 (commit_pc1),
    .pop      (pop),
    .rd_data  (head),
    .level    (level)
  );

  always_ff @(posedge clk or posedge rst_l) begin
    if (rst_l) begin
      piton_pc_vld <= 1'b0;
      piton_pc     <= '0;
      overflow     <= 1'b0;
      drop_cnt     <= '0;
      retire_cnt   <= '0;
    end else begin
      piton_pc_vld <= pop;
      if (pop) piton_pc <= head;
      retire_cnt <= retire_nxt;
      if (n_drop != 2'd0) begin
        overflow <= 1'b1;
        drop_cnt <= drop_sum[DROP_W] ? '1 : drop_sum[DROP_W-1:0];
      end
    end
  end

  assign fifo_level = level;

endmodule

// File: tb/tb_ariane_pc_trace.sv
// Scoreboard bench: a queue-based reference model predicts the trace and counters.
module tb_ariane_pc_trace;
  import ariane_pc_trace_pkg::*;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst_l = 1'b1;
  logic        trace_en = 1'b0;
  logic [1:0]  commit_vld = 2'b00;
  logic [63:0] commit_pc0 = '0;
  logic [63:0] commit_pc1 = '0;
  logic        piton_pc_vld;
  logic [63:0] piton_pc;
  logic        overflow;
  logic [15:0] drop_cnt;
  logic [31:0] retire_cnt;
  logic [2:0]  fifo_level;

  ariane_pc_trace dut (
    .clk          (clk),
    .rst_l        (rst_l),
    .trace_en     (trace_en),
    .commit_vld   (commit_vld),
    .commit_pc0   (commit_pc0),
    .commit_pc1   (commit_pc1),
    .piton_pc_vld (piton_pc_vld),
    .piton_pc     (piton_pc),
    .overflow     (overflow),
    .drop_cnt     (drop_cnt),
    .retire_cnt   (retire_cnt),
    .fifo_level   (fifo_level)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        vld;
    logic [63:0] pc;
    int          level;
    logic        ovf;
    int          drops;
    logic [31:0] retire;
  } stat_t;

  // Reference model state
  logic [63:0] mq[$];
  logic [63:0] exp_q[$];
  stat_t       stat_q[$];
  logic [63:0] m_pc;
  logic        m_ovf;
  int          m_drops;
  logic [31:0] m_retire;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h want %0h at %0t", name, act, req, $time);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    exp_q.delete();
    stat_q.delete();
    m_pc = '0;
    m_ovf = 1'b0;
    m_drops = 0;
    m_retire = '0;
  endtask

  // Drives one commit cycle and predicts the state after the following edge.
  task automatic drive(input logic en, input logic [1:0] vld,
                       input logic [63:0] pc0, input logic [63:0] pc1);
    logic [63:0] req[$];
    int          space;
    logic        popping;
    stat_t       s;
    @(negedge clk);
    trace_en = en;
    commit_vld = vld;
    commit_pc0 = pc0;
    commit_pc1 = pc1;
    if (en && vld[0]) req.push_back(pc0);
    if (en && vld[1]) req.push_back(pc1);
    popping = (mq.size() != 0);
    if (popping) begin
      m_pc = mq.pop_front();
      exp_q.push_back(m_pc);
    end
    space = DEPTH - mq.size();
    foreach (req[i]) begin
      if (space > 0) begin
        mq.push_back(req[i]);
        space--;
      end else begin
        m_ovf = 1'b1;
        m_drops = (m_drops < 65535) ? m_drops + 1 : 65535;
      end
    end
    m_retire = m_retire + 32'(vld[0]) + 32'(vld[1]);
    s.vld = popping;
    s.pc = m_pc;
    s.level = mq.size();
    s.ovf = m_ovf;
    s.drops = m_drops;
    s.retire = m_retire;
    stat_q.push_back(s);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b1, 2'b00, '0, '0);
  endtask

  // Monitor: samples just after each edge and compares against the scoreboard.
  initial begin
    stat_t s;
    logic [63:0] e;
    forever begin
      @(posedge clk);
      #1;
      if (stat_q.size() != 0) begin
        s = stat_q.pop_front();
        check("pc_vld", 64'(piton_pc_vld), 64'(s.vld));
        check("pc_hold", piton_pc, s.pc);
        check("fifo_level", 64'(fifo_level), 64'(s.level));
        check("overflow", 64'(overflow), 64'(s.ovf));
        check("drop_cnt", 64'(drop_cnt), 64'(s.drops));
        check("retire_cnt", 64'(retire_cnt), 64'(s.retire));
      end
      if (piton_pc_vld) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL trace_unexpected: got %0h want none at %0t", piton_pc, $time);
        end else begin
          e = exp_q.pop_front();
          check("trace_pc", piton_pc, e);
        end
      end
    end
  end

  task automatic check_zero(input string tag);
    check({tag, "_vld"}, 64'(piton_pc_vld), 64'd0);
    check({tag, "_pc"}, piton_pc, 64'd0);
    check({tag, "_ovf"}, 64'(overflow), 64'd0);
    check({tag, "_drop"}, 64'(drop_cnt), 64'd0);
    check({tag, "_retire"}, 64'(retire_cnt), 64'd0);
    check({tag, "_level"}, 64'(fifo_level), 64'd0);
  endtask

  initial begin
    logic [63:0] pc;
    logic [1:0]  v;
    logic        en;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_zero("reset");
    @(negedge clk);
    rst_l = 1'b0;

    // Single commits on port 0
    drive(1'b1, 2'b01, 64'h1000, '0);
    drive(1'b1, 2'b01, 64'h1004, '0);
    drive(1'b1, 2'b01, 64'h1008, '0);
    idle(4);
    // Dual commit, then port-1-only commit
    drive(1'b1, 2'b11, 64'h2000, 64'h2004);
    idle(4);
    drive(1'b1, 2'b10, 64'hdead, 64'h3000);
    idle(4);
    // Overflow burst
    for (int i = 0; i < 5; i++)
      drive(1'b1, 2'b11, 64'h5000 + 64'(16*i), 64'h5004 + 64'(16*i));
    idle(8);
    // Gated capture, then a print-via-PC trace
    for (int i = 0; i < 3; i++) drive(1'b0, 2'b01, 64'h6000 + 64'(4*i), '0);
    idle(2);
    drive(1'b1, 2'b01, PRINT_PC_BASE | (64'h41 << 1), '0);
    idle(4);

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      en = ($urandom_range(0, 9) != 0);
      v  = 2'($urandom);
      pc = {32'h0, $urandom} & ~64'h3;
      drive(en, v, pc, pc + 64'd4);
    end
    idle(8);

    // Mid-stream reset with three entries buffered
    drive(1'b1, 2'b11, 64'h7000, 64'h7004);
    drive(1'b1, 2'b11, 64'h7008, 64'h700c);
    @(negedge clk);
    checks++;
    if (fifo_level !== 3'd3) begin
      errors++;
      $display("FAIL pre_reset_level: got %0d want 3", fifo_level);
    end
    rst_l = 1'b1;
    commit_vld = 2'b00;
    #1;
    check_zero("midreset");
    model_reset();
    @(negedge clk);
    rst_l = 1'b0;
    drive(1'b1, 2'b01, 64'h4000, '0);
    idle(6);

    check("scoreboard_drained", 64'(exp_q.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
